piece_bag: RTL and testbench

7-bag tetromino randomizer. Sits directly downstream of the LFSR random generator and consumes its free-running output. Draws piece IDs without replacement from a 7-piece bag, using rejection sampling with a bounded-retry fallback. Buffers them in a small preview FIFO that the game controller pops with a valid/yumi handshake.

---
 rtl/piece_bag.sv | 108 ++++++++++
 tb/tb_piece_bag.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/piece_bag.sv
// piece_bag: 7-bag tetromino randomizer with a depth_p-entry preview FIFO; PIECE_BAG_UNIFORM_EN bypasses the bag.
// Draws land one cycle later; a full FIFO stalls draws unless the head is popped that cycle.
module piece_bag #(
    parameter int rand_width_p = 65,
    parameter int depth_p      = 3,
    parameter int max_retry_p  = 7
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [rand_width_p-1:0]      random_i,
    output logic                         v_o,
    output logic [2:0]                   piece_o,
    input  logic                         yumi_i,
    output logic [3*depth_p-1:0]         preview_o,
    output logic [$clog2(depth_p+1)-1:0] count_o,
    output logic [6:0]                   bag_o
);
    localparam int cnt_w = $clog2(depth_p + 1);
    localparam int ret_w = $clog2(max_retry_p + 1);
    localparam logic [cnt_w-1:0] depth_c     = cnt_w'(depth_p);
    localparam logic [ret_w-1:0] max_retry_c = ret_w'(max_retry_p);

    logic [2:0]       fifo      [depth_p];
    logic [2:0]       fifo_next [depth_p];
    logic [cnt_w-1:0] count, count_next, count_kept;
    logic [6:0]       bag, bag_next;
    logic [ret_w-1:0] retry, retry_next;
    logic             valid;
    logic [2:0]       r, pick;
    logic             pop, draw, fallback, accept, push;

    assign r        = random_i[2:0];
    assign pop      = yumi_i && (count != '0);
    assign draw     = (count != depth_c) || pop;
    assign fallback = (retry == max_retry_c);
    assign push     = draw && (fallback || accept);

    if (rand_width_p > 3) begin : g_unused
        logic unused_rand;
        assign unused_rand = ^random_i[rand_width_p-1:3];
    end

`ifdef PIECE_BAG_UNIFORM_EN
    assign accept   = (r != 3'd7);
    assign pick     = fallback ? 3'd0 : r;
    assign bag_next = 7'h7F;
`else
    logic [7:0] bag8;
    logic [6:0] bag_left;
    logic [2:0] lowest;

    always_comb begin
        lowest = 3'd0;
        for (int p = 6; p >= 0; p--)
            if (bag[p]) lowest = 3'(p);
    end

    // Bit 7 is a permanent zero so r=7 rejects through the same lookup.
    assign bag8     = {1'b0, bag};
    assign accept   = bag8[r];
    assign pick     = fallback ? lowest : r;
    assign bag_left = bag & ~(7'd1 << pick);
    assign bag_next = push ? ((bag_left == '0) ? 7'h7F : bag_left) : bag;
`endif

    always_comb begin
        retry_next = retry;
        if (draw) retry_next = push ? '0 : retry + ret_w'(1);
    end

    always_comb begin
        count_kept = count - cnt_w'(pop);
        for (int k = 0; k < depth_p; k++) fifo_next[k] = fifo[k];
        if (pop) begin
            for (int k = 0; k < depth_p - 1; k++) fifo_next[k] = fifo[k+1];
            fifo_next[depth_p-1] = 3'd0;
        end
        // Tail slot is measured after the pop so push and pop compose.
        for (int k = 0; k < depth_p; k++)
            if (push && (cnt_w'(k) == count_kept)) fifo_next[k] = pick;
        count_next = count_kept + cnt_w'(push);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < depth_p; k++) fifo[k] <= 3'd0;
            count <= '0;
            bag   <= 7'h7F;
            retry <= '0;
            valid <= 1'b0;
        end else begin
            fifo  <= fifo_next;
            count <= count_next;
            bag   <= bag_next;
            retry <= retry_next;
            valid <= (count_next != '0);
        end
    end

    assign v_o     = valid;
    assign piece_o = fifo[0];
    assign count_o = count;
    assign bag_o   = bag;

    for (genvar k = 0; k < depth_p; k++) begin : g_prev
        assign preview_o[3*k +: 3] = fifo[k];
    end
endmodule

// File: tb/tb_piece_bag.sv
// Bench for piece_bag: queue/set model checked every cycle plus hand-computed directed expectations.
module tb_piece_bag;
    localparam int RW    = 65;
    localparam int DEPTH = 3;
    localparam int MAXR  = 7;
    localparam int CW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic [RW-1:0]     random_i = '0;
    logic              yumi_i = 1'b0;
    logic              v_o;
    logic [2:0]        piece_o;
    logic [3*DEPTH-1:0] preview_o;
    logic [CW-1:0]     count_o;
    logic [6:0]        bag_o;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    piece_bag #(.rand_width_p(RW), .depth_p(DEPTH), .max_retry_p(MAXR)) dut (
        .clk_i(clk), .reset_i(reset_i), .random_i(random_i), .v_o(v_o),
        .piece_o(piece_o), .yumi_i(yumi_i), .preview_o(preview_o),
        .count_o(count_o), .bag_o(bag_o)
    );

    always #5 clk = ~clk;

    // Model: FIFO as a queue, bag as a set of remaining pieces, retry as a plain count.
    logic [2:0] mq[$];
    bit   [6:0] m_bag = 7'h7F;
    int         m_retry = 0;
    int         m_r;
    int         m_got;

    always @(posedge clk) begin
        if (reset_i) begin
            mq.delete();
            m_bag = 7'h7F;
            m_retry = 0;
        end else begin
            m_r = int'(random_i[2:0]);
            if (yumi_i && mq.size() > 0) void'(mq.pop_front());
            if (mq.size() < DEPTH) begin
                m_got = -1;
                if (m_retry == MAXR) begin
                    for (int p = 0; p < 7; p++)
                        if (m_bag[p] && m_got < 0) m_got = p;
                end else if (m_r < 7 && m_bag[m_r]) begin
                    m_got = m_r;
                end
                if (m_got >= 0) begin
                    mq.push_back(3'(m_got));
                    m_bag[m_got] = 1'b0;
                    m_retry = 0;
                end else begin
                    m_retry++;
                end
            end
            if (m_bag == 7'd0) m_bag = 7'h7F;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [3*DEPTH-1:0] e_prev;
    always @(negedge clk) begin
        if (chk_en) begin
            e_prev = '0;
            for (int k = 0; k < mq.size(); k++) e_prev[3*k +: 3] = mq[k];
            chk("model_v", 64'(v_o), 64'(mq.size() > 0));
            chk("model_piece", 64'(piece_o), (mq.size() > 0) ? 64'(mq[0]) : 64'd0);
            chk("model_count", 64'(count_o), 64'(mq.size()));
            chk("model_preview", 64'(preview_o), 64'(e_prev));
            chk("model_bag", 64'(bag_o), 64'(m_bag));
        end
    end

    task automatic drive(input logic [2:0] r, input logic y);
        logic [95:0] w;
        w = {$urandom(), $urandom(), $urandom()};
        random_i = w[RW-1:0];
        random_i[2:0] = r;
        yumi_i = y;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        drive(3'd0, 1'b0);
        reset_i = 1'b0;
    endtask

    logic [2:0] seq3[6] = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    initial begin
        do_reset();
        chk_en = 1'b1;
        chk("rst_v", 64'(v_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_bag", 64'(bag_o), 64'h7F);
        chk("rst_preview", 64'(preview_o), 64'd0);
        chk("rst_piece", 64'(piece_o), 64'd0);

        // Ordered draws, no pops
        drive(3'd0, 1'b0);
        chk("t1_first_v", 64'(v_o), 64'd1);
        drive(3'd1, 1'b0);
        drive(3'd2, 1'b0);
        chk("t1_count", 64'(count_o), 64'd3);
        chk("t1_preview", 64'(preview_o), 64'h088);
        chk("t1_bag", 64'(bag_o), 64'h78);
        drive(3'd3, 1'b0);
        drive(3'd4, 1'b0);
        chk("t1_stall_bag", 64'(bag_o), 64'h78);
        chk("t1_stall_preview", 64'(preview_o), 64'h088);

        // Fallback after repeated rejects
        do_reset();
        drive(3'd2, 1'b0);
        chk("t2_piece_T", 64'(piece_o), 64'd2);
        for (int i = 0; i < 7; i++) drive(3'd2, mq.size() > 0);
        chk("t2_rejects_v", 64'(v_o), 64'd0);
        chk("t2_rejects_bag", 64'(bag_o), 64'h7B);
        drive(3'd2, 1'b0);
        chk("t2_fallback_piece", 64'(piece_o), 64'd0);
        chk("t2_fallback_v", 64'(v_o), 64'd1);
        chk("t2_fallback_bag", 64'(bag_o), 64'h7A);

        // Bag refill
        do_reset();
        drive(3'd6, 1'b0);
        chk("t3_piece6", 64'(piece_o), 64'd6);
        for (int i = 0; i < 6; i++) begin
            drive(seq3[i], 1'b1);
            chk("t3_piece", 64'(piece_o), 64'(seq3[i]));
            if (i == 4) chk("t3_bag_last", 64'(bag_o), 64'h01);
        end
        chk("t3_refill", 64'(bag_o), 64'h7F);

        // Reject on r = 7
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(3'd7, 1'b0);
            chk("t4_v", 64'(v_o), 64'd0);
            chk("t4_bag", 64'(bag_o), 64'h7F);
        end
        drive(3'd4, 1'b0);
        chk("t4_piece_Z", 64'(piece_o), 64'd4);
        chk("t4_v_after", 64'(v_o), 64'd1);

        // Pop and push on a full FIFO
        do_reset();
        drive(3'd6, 1'b0);
        drive(3'd0, 1'b0);
        drive(3'd1, 1'b0);
        chk("t5_full_preview", 64'(preview_o), 64'h046);
        drive(3'd3, 1'b1);
        chk("t5_piece", 64'(piece_o), 64'd0);
        chk("t5_preview", 64'(preview_o), 64'h0C8);
        chk("t5_count", 64'(count_o), 64'd3);

        // Reset mid-operation
        do_reset();
        drive(3'd6, 1'b0);
        drive(3'd5, 1'b0);
        chk("t6_pre_count", 64'(count_o), 64'd2);
        chk("t6_pre_bag", 64'(bag_o), 64'h1F);
        reset_i = 1'b1;
        drive(3'd3, 1'b1);
        reset_i = 1'b0;
        chk("t6_v", 64'(v_o), 64'd0);
        chk("t6_count", 64'(count_o), 64'd0);
        chk("t6_bag", 64'(bag_o), 64'h7F);
        chk("t6_preview", 64'(preview_o), 64'd0);

        // Mixed traffic, checked by the model every cycle
        for (int i = 0; i < 400; i++)
            drive(3'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1) && (mq.size() > 0));

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
